usb_fifo_reader: RTL and testbench
==================================

USB_FIFO_READER -- requirements
Module: usb_fifo_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning receive-buffer depth in words (power of two, >= 8).
REQ-002 SHALL have parameter START_FREE, default 4, meaning minimum free buffer entries required to start a burst.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RXF_N  input  1  FIFO chip "receive data available", active low.
REQ-006 SHALL have port OE_N  output  1  bus output enable to FIFO chip, active low, registered.
REQ-007 SHALL have port RD_N  output  1  read strobe to FIFO chip, active low, registered.
REQ-008 SHALL have port DATA  input  16  read data from FIFO chip (tristate handled at top level).
REQ-009 SHALL have port BE  input  2  byte enables accompanying DATA.
REQ-010 SHALL have port out_data  output  16  head-of-buffer data word.
REQ-011 SHALL have port out_be  output  2  head-of-buffer byte enables.
REQ-012 SHALL have port out_valid  output  1  buffer not empty.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head word.
REQ-014 SHALL have port word_count  output  16  total words received since reset, wraps modulo 2^16.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, OE, READ, STOP, all transitions on rising CLK.
REQ-017 IDLE: if RXF_N==0 and free entries >= START_FREE, SHALL drive OE_N<=0 and go to OE; else stay.
REQ-018 OE: SHALL drive RD_N<=0 and go to READ (one bus-turnaround cycle, no capture).
REQ-019 Capture rule: on an edge where RD_N==0 and RXF_N==0, SHALL push {BE,DATA} into the buffer and increment word_count.
REQ-020 READ: if RXF_N==1, or free entries after this edge's push and pop <= 2, SHALL drive RD_N<=1, OE_N<=1 and go to STOP.
REQ-021 STOP: SHALL go to IDLE after exactly one cycle with OE_N=1, RD_N=1; no new burst may begin in STOP.
REQ-022 Pop rule: SHALL pop the head on an edge where out_valid==1 and out_ready==1.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, including when full or empty-before-push.
REQ-024 out_data/out_be SHALL reflect the head entry combinationally from buffer storage; out_valid = (occupancy != 0).
REQ-025 Push SHALL never occur when full; REQ-020 guarantees this; a push attempted when full SHALL be dropped, not wrap.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-027 Words SHALL emerge on out_data in capture order with no duplication or loss.
REQ-028 Minimum latency: RXF_N falls at edge N in IDLE -> OE_N low after N, RD_N low after N+1, first capture at N+2, out_valid high after N+2.
REQ-029 OE_N SHALL be low whenever RD_N is low; RD_N SHALL never be low in IDLE or STOP.

Reset
REQ-030 On RST==1 at a rising edge: state<=IDLE, OE_N<=1, RD_N<=1, pointers and occupancy<=0, word_count<=0, out_valid=0, busy=0.
REQ-031 RST SHALL take priority over every other event, including mid-burst capture at the same edge (no push, no count).
REQ-032 After RST deasserts, a new burst SHALL start per REQ-017 no earlier than the following edge.

Verification
REQ-033 Single word: RXF_N low for exactly one capture edge, out_ready=1 -> one word 0x1234/BE=3 out, word_count=1, sequence IDLE->OE->READ->STOP->IDLE.
REQ-034 Burst with backpressure: host supplies 20 words 0..19, out_ready=0 -> burst stops with 6 words buffered (8-2); after draining, resumes; all 20 words delivered in order, word_count=20.
REQ-035 Full-rate streaming: out_ready=1 permanently, RXF_N low for 100 words -> single continuous burst, one capture per cycle, no stall, word_count=100.
REQ-036 Start threshold: buffer holds 5 words, out_ready=0, RXF_N low -> OE_N stays 1 until occupancy <= 4.
REQ-037 Reset mid-burst: RST asserted during READ at a capture edge -> next cycle OE_N=1, RD_N=1, out_valid=0, word_count=0, no word captured.
REQ-038 Wrap: 65537 words streamed -> word_count=1; buffer pointers wrap repeatedly with data order preserved.

Source files
------------

// File: rtl/usb_fifo_reader.sv
// Burst reader for an FT-style USB FIFO chip: drives OE_N/RD_N and captures
// {BE,DATA} into a small receive buffer that a ready/valid consumer drains.
module usb_fifo_reader #(
   parameter int DEPTH      = 8,
   parameter int START_FREE = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RXF_N,
   output logic        OE_N,
   output logic        RD_N,
   input  logic [15:0] DATA,
   input  logic [1:0]  BE,
   output logic [15:0] out_data,
   output logic [1:0]  out_be,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] word_count,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, OE, READ, STOP} state_t;

   state_t          state_q;
   logic            oeN_q;
   logic            rdN_q;
   logic [AW-1:0]   wrPtr_q;
   logic [AW-1:0]   wrPtr_d;
   logic [AW-1:0]   rdPtr_q;
   logic [AW-1:0]   rdPtr_d;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [15:0]     wordCount_q;
   logic [15:0]     wordCount_d;
   logic [CW-1:0]   freeNow;
   logic [CW-1:0]   freeAfter;
   logic            full;
   logic            capture;
   logic            push;
   logic            pop;
   logic [17:0]     mem [DEPTH];

   // A capture while full is only accepted if the head leaves on the same edge.
   always_comb begin
      full        = (count_q == CW'(DEPTH));
      capture     = !rdN_q && !RXF_N;
      pop         = (count_q != '0) && out_ready;
      push        = capture && (!full || pop);
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      wordCount_d = wordCount_q;
      if (push) begin
         wrPtr_d     = wrPtr_q + 1'b1;
         wordCount_d = wordCount_q + 16'd1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      freeNow   = CW'(DEPTH) - count_q;
      freeAfter = CW'(DEPTH) - count_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         wordCount_q <= '0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         wordCount_q <= wordCount_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         mem[wrPtr_q] <= {BE, DATA};
      end
   end

   // Bursts end while two entries remain free, which covers the words the
   // chip may still present before RD_N deasserts.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         oeN_q   <= 1'b1;
         rdN_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!RXF_N && (freeNow >= CW'(START_FREE))) begin
                  oeN_q   <= 1'b0;
                  state_q <= OE;
               end
            end
            OE: begin
               rdN_q   <= 1'b0;
               state_q <= READ;
            end
            READ: begin
               if (RXF_N || (freeAfter <= CW'(2))) begin
                  rdN_q   <= 1'b1;
                  oeN_q   <= 1'b1;
                  state_q <= STOP;
               end
            end
            STOP: begin
               oeN_q   <= 1'b1;
               rdN_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               oeN_q   <= 1'b1;
               rdN_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign OE_N       = oeN_q;
   assign RD_N       = rdN_q;
   assign out_data   = mem[rdPtr_q][15:0];
   assign out_be     = mem[rdPtr_q][17:16];
   assign out_valid  = (count_q != '0);
   assign word_count = wordCount_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_usb_fifo_reader.sv
// Bench for usb_fifo_reader: a FIFO-chip model feeds words, a queue-based
// reference predicts bus strobes, buffer contents and the word counter.
module tb_usb_fifo_reader;

   localparam int DEPTH      = 8;
   localparam int START_FREE = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        RXF_N = 1'b1;
   logic        OE_N;
   logic        RD_N;
   logic [15:0] DATA = 16'h0;
   logic [1:0]  BE = 2'b0;
   logic [15:0] out_data;
   logic [1:0]  out_be;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] word_count;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [17:0] hostQ[$];
   logic [17:0] modelQ[$];
   logic [15:0] modelCount = 16'd0;
   int          delivered = 0;
   bit          rxfHold = 1'b0;

   typedef struct {
      logic        rxfN;
      logic        ready;
      logic        expOe;
      logic        expRd;
      logic        expValid;
      logic        expBusy;
      logic [15:0] expCount;
   } vec_t;

   vec_t vecs[6];

   always #5 CLK = ~CLK;

   usb_fifo_reader #(.DEPTH(DEPTH), .START_FREE(START_FREE)) dut (
      .CLK(CLK), .RST(RST), .RXF_N(RXF_N), .OE_N(OE_N), .RD_N(RD_N),
      .DATA(DATA), .BE(BE), .out_data(out_data), .out_be(out_be),
      .out_valid(out_valid), .out_ready(out_ready),
      .word_count(word_count), .busy(busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s timed out", name);
   endtask

   // The chip presents its head word and signals "data available" when it has one.
   task automatic driveInputs();
      RXF_N = (hostQ.size() == 0) || rxfHold;
      if (hostQ.size() != 0) {BE, DATA} = hostQ[0];
      else                   {BE, DATA} = 18'($urandom);
   endtask

   // One clock: predict the edge from the bus rules, then compare all outputs.
   task automatic applyStimulus();
      logic preRst, preRxf, preRdy, preOe, preRd, preBusy;
      logic expOe, expRd, expBusy, go, stop;
      logic [17:0] w;
      int occPre, occPost;
      preRst  = RST;
      preRxf  = RXF_N;
      preRdy  = out_ready;
      preOe   = OE_N;
      preRd   = RD_N;
      preBusy = busy;
      occPre  = modelQ.size();
      if (!preRst && occPre != 0) begin
         checkOutput("headData", 32'(out_data), 32'(modelQ[0][15:0]));
         checkOutput("headBe", 32'(out_be), 32'(modelQ[0][17:16]));
      end
      @(posedge CLK);
      #1;
      if (preRst) begin
         modelQ.delete();
         modelCount = 16'd0;
         expOe   = 1'b1;
         expRd   = 1'b1;
         expBusy = 1'b0;
      end else begin
         if (occPre != 0 && preRdy) begin
            void'(modelQ.pop_front());
            delivered++;
         end
         if (!preRd && !preRxf && hostQ.size() != 0) begin
            w = hostQ.pop_front();
            if (modelQ.size() < DEPTH) begin
               modelQ.push_back(w);
               modelCount = modelCount + 16'd1;
            end
         end
         occPost = modelQ.size();
         if (!preBusy) begin
            go      = !preRxf && ((DEPTH - occPre) >= START_FREE);
            expOe   = !go;
            expRd   = 1'b1;
            expBusy = go;
         end else if (!preOe && preRd) begin
            expOe   = 1'b0;
            expRd   = 1'b0;
            expBusy = 1'b1;
         end else if (!preRd) begin
            stop    = preRxf || ((DEPTH - occPost) <= 2);
            expOe   = stop;
            expRd   = stop;
            expBusy = 1'b1;
         end else begin
            expOe   = 1'b1;
            expRd   = 1'b1;
            expBusy = 1'b0;
         end
      end
      checkOutput("OE_N", 32'(OE_N), 32'(expOe));
      checkOutput("RD_N", 32'(RD_N), 32'(expRd));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
      checkOutput("word_count", 32'(word_count), 32'(modelCount));
      driveInputs();
   endtask

   task automatic applyReset();
      RST = 1'b1;
      rxfHold = 1'b0;
      out_ready = 1'b0;
      hostQ.delete();
      driveInputs();
      applyStimulus();
      RST = 1'b0;
      delivered = 0;
      driveInputs();
   endtask

   task automatic drainAll(input string name, input int budget);
      int n;
      n = 0;
      out_ready = 1'b1;
      rxfHold = 1'b0;
      driveInputs();
      while ((hostQ.size() != 0 || modelQ.size() != 0 || busy) && n < budget) begin
         applyStimulus();
         n++;
      end
      if (n >= budget) timeoutFail(name);
   endtask

   initial begin
      int n;
      // Single word 0x1234/BE=3: IDLE->OE->READ(capture)->STOP->IDLE
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};

      applyReset();
      DATA = 16'h1234;
      BE   = 2'b11;
      for (int i = 0; i < 6; i++) begin
         RXF_N     = vecs[i].rxfN;
         out_ready = vecs[i].ready;
         @(posedge CLK);
         #1;
         checkOutput($sformatf("vec%0d.OE_N", i), 32'(OE_N), 32'(vecs[i].expOe));
         checkOutput($sformatf("vec%0d.RD_N", i), 32'(RD_N), 32'(vecs[i].expRd));
         checkOutput($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d.count", i), 32'(word_count), 32'(vecs[i].expCount));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d.data", i), 32'(out_data), 32'h1234);
            checkOutput($sformatf("vec%0d.be", i), 32'(out_be), 32'h3);
         end
      end

      // Backpressure: six words buffered, then the rest after draining
      applyReset();
      for (int i = 0; i < 20; i++) hostQ.push_back({2'b11, 16'(i)});
      driveInputs();
      for (int i = 0; i < 12; i++) applyStimulus();
      checkOutput("bufferedWords", 32'(20 - hostQ.size()), 32'd6);
      checkOutput("burstStopped", 32'(OE_N), 32'd1);
      drainAll("backpressureDrain", 300);
      checkOutput("backpressureDelivered", 32'(delivered), 32'd20);
      checkOutput("backpressureCount", 32'(word_count), 32'd20);

      // Start threshold with five words held
      applyReset();
      for (int i = 0; i < 5; i++) hostQ.push_back(18'($urandom));
      driveInputs();
      for (int i = 0; i < 10; i++) applyStimulus();
      for (int i = 0; i < 3; i++) hostQ.push_back(18'($urandom));
      driveInputs();
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("thresholdHold", 32'(OE_N), 32'd1);
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;
      applyStimulus();
      checkOutput("thresholdStart", 32'(OE_N), 32'd0);
      drainAll("thresholdDrain", 200);

      // Reset during a capture edge
      applyReset();
      for (int i = 0; i < 10; i++) hostQ.push_back(18'($urandom));
      driveInputs();
      n = 0;
      while (RD_N !== 1'b0 && n < 20) begin
         applyStimulus();
         n++;
      end
      if (n >= 20) timeoutFail("midBurstStart");
      applyStimulus();
      RST = 1'b1;
      applyStimulus();
      RST = 1'b0;
      checkOutput("midResetOE", 32'(OE_N), 32'd1);
      checkOutput("midResetRD", 32'(RD_N), 32'd1);
      checkOutput("midResetValid", 32'(out_valid), 32'd0);
      checkOutput("midResetCount", 32'(word_count), 32'd0);
      drainAll("midResetDrain", 200);

      // Full-rate streaming: one capture per cycle, no stall
      applyReset();
      for (int i = 0; i < 100; i++) hostQ.push_back(18'($urandom));
      out_ready = 1'b1;
      driveInputs();
      n = 0;
      while (OE_N !== 1'b0 && n < 10) begin
         applyStimulus();
         n++;
      end
      if (n >= 10) timeoutFail("streamStart");
      n = 0;
      while (hostQ.size() != 0 && n < 300) begin
         applyStimulus();
         n++;
      end
      checkOutput("streamCycles", 32'(n), 32'd101);
      drainAll("streamDrain", 50);
      checkOutput("streamCount", 32'(word_count), 32'd100);
      checkOutput("streamDelivered", 32'(delivered), 32'd100);

      // Random traffic with stalls, backpressure and occasional resets
      applyReset();
      for (int i = 0; i < 3000; i++) begin
         if (hostQ.size() < 4 && $urandom_range(3) == 0) begin
            for (int k = 0; k < int'($urandom_range(12)); k++) hostQ.push_back(18'($urandom));
         end
         out_ready = ($urandom_range(2) != 0);
         rxfHold   = ($urandom_range(4) == 0);
         RST       = ($urandom_range(299) == 0);
         driveInputs();
         applyStimulus();
      end
      RST = 1'b0;
      drainAll("randomDrain", 500);

      // Counter wrap over 65537 words
      applyReset();
      for (int i = 0; i < 65537; i++) hostQ.push_back(18'($urandom));
      drainAll("wrapDrain", 70000);
      checkOutput("wrapCount", 32'(word_count), 32'd1);
      checkOutput("wrapDelivered", 32'(delivered), 32'd65537);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
